// File: rtl/tx_message_buffer.sv
// Transmit queue between the core and the UART: words are queued with a byte
// count, then serialised low byte first over the SendTx/UART_Done handshake.
module tx_message_buffer #(
    parameter int WORD_WIDTH = 32,
    parameter int DEPTH      = 4,
    localparam int BYTES     = WORD_WIDTH / 8,
    localparam int BCNT_W    = $clog2(BYTES) + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WORD_WIDTH-1:0] push_data,
    input  logic [BCNT_W-1:0]     push_bytes,
    input  logic                  UART_Done,
    output logic                  SendTx,
    output logic [7:0]            Message,
    output logic                  full,
    output logic                  empty,
    output logic                  busy,
    output logic                  overflow
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = BCNT_W + WORD_WIDTH;

    typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} state_t;

    state_t                    state;
    logic [ENTRY_W-1:0]        mem [DEPTH];
    logic [PTR_W-1:0]          wr_ptr, rd_ptr;
    logic [CNT_W-1:0]          count, count_nxt;
    logic [ENTRY_W-1:0]        head;
    logic [WORD_WIDTH-1:0]     sh, sh_next;
    logic [BCNT_W-1:0]         rem;
    logic                      do_pop, do_push;

    // A count of zero or anything beyond the word width means "whole word".
    function automatic logic [BCNT_W-1:0] norm_bytes(input logic [BCNT_W-1:0] b);
        if (b == '0 || b > BCNT_W'(BYTES))
            return BCNT_W'(BYTES);
        return b;
    endfunction

    assign do_pop  = (state == IDLE) && !empty;
    assign do_push = push && (!full || do_pop);
    assign sh_next = sh >> 8;

    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop)
            count_nxt = count + CNT_W'(1);
        else if (!do_push && do_pop)
            count_nxt = count - CNT_W'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && full && !do_pop)
                overflow <= 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == CNT_W'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    // Storage and shift data carry no reset; control decides when they matter.
    // The head entry is latched at pop time because a same-cycle push into a
    // full FIFO reuses the slot that was just freed.
    always_ff @(posedge clock) begin
        if (do_push)
            mem[wr_ptr] <= {norm_bytes(push_bytes), push_data};
        if (do_pop)
            head <= mem[rd_ptr];
        if (state == LOAD)
            sh <= head[WORD_WIDTH-1:0];
        else if (state == WAIT && UART_Done)
            sh <= sh_next;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            SendTx  <= 1'b0;
            Message <= 8'h00;
            busy    <= 1'b0;
            rem     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (do_pop) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    rem     <= head[ENTRY_W-1 -: BCNT_W];
                    Message <= head[7:0];
                    SendTx  <= 1'b1;
                    state   <= SEND;
                end
                SEND: begin
                    SendTx <= 1'b0;
                    state  <= WAIT;
                end
                WAIT: begin
                    if (UART_Done) begin
                        rem <= rem - BCNT_W'(1);
                        if (rem == BCNT_W'(1)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            Message <= sh_next[7:0];
                            SendTx  <= 1'b1;
                            state   <= SEND;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_message_buffer.sv
// Directed bench for tx_message_buffer: byte order, latency, FIFO full/overflow,
// coincident push/pop, mid-word reset and ignored UART_Done pulses.
module tb_tx_message_buffer;

    localparam int WORD_WIDTH = 32;
    localparam int DEPTH      = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        push = 1'b0;
    logic [31:0] push_data = '0;
    logic [2:0]  push_bytes = '0;
    logic        UART_Done = 1'b0;
    logic        SendTx;
    logic [7:0]  Message;
    logic        full, empty, busy, overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int tx_count = 0;

    tx_message_buffer #(.WORD_WIDTH(WORD_WIDTH), .DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_data  (push_data),
        .push_bytes (push_bytes),
        .UART_Done  (UART_Done),
        .SendTx     (SendTx),
        .Message    (Message),
        .full       (full),
        .empty      (empty),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (SendTx === 1'b1) tx_count++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns at the negedge of the SendTx cycle; waited = negedges spent.
    task automatic wait_tx(input string tag, input logic [7:0] exp, output int waited);
        waited = 0;
        while (SendTx !== 1'b1 && waited < 40) begin
            @(negedge clock);
            waited++;
        end
        check({tag, "_sendtx"}, SendTx, 1'b1);
        check({tag, "_msg"}, Message, exp);
    endtask

    // UART_Done five cycles after SendTx; returns at negedge of the following cycle.
    task automatic respond(input string tag, input logic [7:0] exp);
        repeat (5) @(negedge clock);
        UART_Done = 1'b1;
        check({tag, "_stable"}, Message, exp);
        @(negedge clock);
        UART_Done = 1'b0;
    endtask

    task automatic send_byte(input string tag, input logic [7:0] exp);
        int w;
        wait_tx(tag, exp, w);
        respond(tag, exp);
    endtask

    task automatic no_tx(input string tag, input int n);
        int cnt = 0;
        repeat (n) begin
            @(negedge clock);
            if (SendTx !== 1'b0) cnt++;
        end
        check(tag, cnt, 0);
    endtask

    task automatic reset_pulse();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic fill_five(input logic [7:0] base);
        for (int i = 0; i < 5; i++) begin
            push       = 1'b1;
            push_data  = {24'h0, base + 8'(i)};
            push_bytes = 3'd1;
            @(negedge clock);
        end
    endtask

    initial begin
        int w;
        int t0;
        logic [7:0] exp2 [5];
        exp2 = '{8'hAA, 8'hCC, 8'hBB, 8'h00, 8'h00};

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_sendtx", SendTx, 1'b0);
        check("rst_message", Message, 8'h00);
        check("rst_full", full, 1'b0);
        check("rst_empty", empty, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        reset = 1'b1;

        // Test 1: four-byte word, low byte first
        @(negedge clock);
        push = 1'b1; push_data = 32'h44434241; push_bytes = 3'd4;
        @(negedge clock);
        push = 1'b0;
        check("t1_empty_fall", empty, 1'b0);
        check("t1_idle_pop", busy, 1'b0);
        wait_tx("t1_b0", 8'h41, w);
        check("t1_first_latency", w, 2);
        respond("t1_b0", 8'h41);
        wait_tx("t1_b1", 8'h42, w);
        check("t1_gap", w, 0);
        respond("t1_b1", 8'h42);
        send_byte("t1_b2", 8'h43);
        send_byte("t1_b3", 8'h44);
        check("t1_busy_end", busy, 1'b0);
        check("t1_empty_end", empty, 1'b1);

        // Test 2: back-to-back pushes, count 1 and count 0 (= whole word)
        t0 = tx_count;
        push = 1'b1; push_data = 32'h000000AA; push_bytes = 3'd1;
        @(negedge clock);
        push_data = 32'h0000BBCC; push_bytes = 3'd0;
        @(negedge clock);
        push = 1'b0;
        for (int i = 0; i < 5; i++)
            send_byte($sformatf("t2_b%0d", i), exp2[i]);
        no_tx("t2_extra_tx", 12);
        check("t2_tx_count", tx_count - t0, 5);

        // Test 2b: count above BYTES also means the whole word
        push = 1'b1; push_data = 32'h0D0C0B0A; push_bytes = 3'd7;
        @(negedge clock);
        push = 1'b0;
        send_byte("t2b_b0", 8'h0A);
        send_byte("t2b_b1", 8'h0B);
        send_byte("t2b_b2", 8'h0C);
        send_byte("t2b_b3", 8'h0D);
        no_tx("t2b_extra_tx", 12);

        // Test 3: fill FIFO with UART stalled, then overflow
        reset_pulse();
        fill_five(8'h11);
        check("t3_full", full, 1'b1);
        check("t3_no_overflow", overflow, 1'b0);
        push_data = 32'h00000066;
        @(negedge clock);
        push = 1'b0;
        check("t3_overflow", overflow, 1'b1);
        check("t3_still_full", full, 1'b1);
        check("t3_inflight_msg", Message, 8'h11);
        UART_Done = 1'b1;
        @(negedge clock);
        UART_Done = 1'b0;
        send_byte("t3_w2", 8'h12);
        send_byte("t3_w3", 8'h13);
        send_byte("t3_w4", 8'h14);
        send_byte("t3_w5", 8'h15);
        no_tx("t3_dropped_not_sent", 12);
        check("t3_empty", empty, 1'b1);
        check("t3_overflow_sticky", overflow, 1'b1);

        // Test 4: push while full in the same cycle as a pop
        reset_pulse();
        fill_five(8'hA1);
        push = 1'b0;
        check("t4_full", full, 1'b1);
        UART_Done = 1'b1;
        @(negedge clock);
        UART_Done = 1'b0;
        check("t4_idle", busy, 1'b0);
        push = 1'b1; push_data = 32'h000000A6; push_bytes = 3'd1;
        @(negedge clock);
        push = 1'b0;
        check("t4_full_kept", full, 1'b1);
        check("t4_no_overflow", overflow, 1'b0);
        check("t4_loading", busy, 1'b1);
        for (int i = 0; i < 5; i++)
            send_byte($sformatf("t4_w%0d", i + 2), 8'hA2 + 8'(i));
        no_tx("t4_extra_tx", 12);
        check("t4_empty", empty, 1'b1);

        // Test 5: reset during WAIT of byte 2 with two entries queued
        reset_pulse();
        push = 1'b1; push_data = 32'h04030201; push_bytes = 3'd4;
        @(negedge clock);
        push_data = 32'h00000077; push_bytes = 3'd1;
        @(negedge clock);
        push_data = 32'h00000088;
        @(negedge clock);
        push = 1'b0;
        send_byte("t5_b0", 8'h01);
        wait_tx("t5_b1", 8'h02, w);
        @(negedge clock);
        check("t5_in_wait", busy, 1'b1);
        reset = 1'b0;
        #1;
        check("t5_rst_sendtx", SendTx, 1'b0);
        check("t5_rst_message", Message, 8'h00);
        check("t5_rst_empty", empty, 1'b1);
        check("t5_rst_full", full, 1'b0);
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_overflow", overflow, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        no_tx("t5_quiet", 20);
        check("t5_empty_after", empty, 1'b1);
        push = 1'b1; push_data = 32'h0000005A; push_bytes = 3'd1;
        @(negedge clock);
        push = 1'b0;
        send_byte("t5_new", 8'h5A);

        // Test 6: UART_Done in IDLE and in the SEND cycle is ignored
        @(negedge clock);
        UART_Done = 1'b1;
        @(negedge clock);
        UART_Done = 1'b0;
        check("t6_idle_busy", busy, 1'b0);
        check("t6_idle_sendtx", SendTx, 1'b0);
        push = 1'b1; push_data = 32'h0000C3B2; push_bytes = 3'd2;
        @(negedge clock);
        push = 1'b0;
        wait_tx("t6_b0", 8'hB2, w);
        UART_Done = 1'b1;
        @(negedge clock);
        UART_Done = 1'b0;
        check("t6_wait_sendtx", SendTx, 1'b0);
        check("t6_wait_busy", busy, 1'b1);
        check("t6_wait_msg", Message, 8'hB2);
        respond("t6_b0", 8'hB2);
        wait_tx("t6_b1", 8'hC3, w);
        check("t6_gap", w, 0);
        respond("t6_b1", 8'hC3);
        check("t6_busy_end", busy, 1'b0);
        check("t6_empty_end", empty, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
